time_set_ctrl: RTL

Timekeeping and time-setting controller for the clock. It consumes the three debounced, active-high key levels from the key front end: mode, increment and decrement. It also takes the 1 Hz tick. It maintains hours/minutes/seconds in binary and implements the RUN/SET mode state machine, with single-step and auto-repeat adjustment. Its outputs feed the display formatter and the set-mode blink logic.

---
 rtl/time_set_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: keeps hh:mm:ss in binary and runs the RUN/SET mode machine.
// Fields are adjusted in SET states by single-step presses and by auto-repeat.
module time_set_ctrl #(
  parameter int unsigned HOLD_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] key_lvl,
  input  logic       tick_1hz,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] set_mode,
  output logic       upd
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  // The counter only ever reaches (threshold - 1), so log2 of the larger threshold is enough.
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [5:0]  HOUR_MAX = 6'd23;
  localparam logic [5:0]  MS_MAX   = 6'd59;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       key_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rep_q, rep_d;
  logic [4:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             upd_q, upd_d;

  logic [2:0]       press;
  logic             step_up;
  logic             step_dn;

  // Wrapping +/-1 on a field with the given maximum; never touches other fields.
  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] vmax,
                                            input logic up);
    logic [5:0] r;
    if (up) r = (v >= vmax) ? 6'd0 : v + 6'd1;
    else    r = (v == 6'd0) ? vmax : v - 6'd1;
    return r;
  endfunction

  // Rising-edge detect on the debounced key levels.
  always_comb begin
    press = key_lvl & ~key_prev_q;
  end

  // Mode state machine: advances only on a mode-key press.
  always_comb begin
    state_d = state_q;
    if (press[0]) begin
      unique case (state_q)
        ST_RUN:      state_d = ST_SET_HOUR;
        ST_SET_HOUR: state_d = ST_SET_MIN;
        ST_SET_MIN:  state_d = ST_SET_SEC;
        ST_SET_SEC:  state_d = ST_RUN;
        default:     state_d = ST_RUN;
      endcase
    end
  end

  // Step requests and hold/repeat counter; a mode press or both keys high suppresses stepping.
  always_comb begin
    cnt_d   = '0;
    rep_d   = 1'b0;
    step_up = 1'b0;
    step_dn = 1'b0;
    if ((state_q != ST_RUN) && !press[0] && (key_lvl[1] ^ key_lvl[2])) begin
      if (press[1] || press[2]) begin
        step_up = press[1];
        step_dn = press[2];
      end else if (rep_q ? (cnt_q == CNT_W'(REPEAT_CYCLES - 1))
                         : (cnt_q == CNT_W'(HOLD_CYCLES - 1))) begin
        step_up = key_lvl[1];
        step_dn = key_lvl[2];
        rep_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        rep_d = rep_q;
      end
    end
  end

  // Time fields: tick with carries in RUN (pre-edge state decides), wrapping set steps otherwise.
  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (state_q == ST_RUN) begin
      if (tick_1hz) begin
        if (sec_q == MS_MAX) begin
          sec_d = 6'd0;
          if (min_q == MS_MAX) begin
            min_d  = 6'd0;
            hour_d = (hour_q == 5'(HOUR_MAX)) ? 5'd0 : hour_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
    end else if (step_up || step_dn) begin
      unique case (state_q)
        ST_SET_HOUR: hour_d = 5'(step_field({1'b0, hour_q}, HOUR_MAX, step_up));
        ST_SET_MIN:  min_d  = step_field(min_q, MS_MAX, step_up);
        ST_SET_SEC:  sec_d  = step_field(sec_q, MS_MAX, step_up);
        default:     ;
      endcase
    end
    upd_d = (hour_d != hour_q) || (min_d != min_q) || (sec_d != sec_q);
  end

  // All state registers; key_prev resets high so a key held through reset is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      key_prev_q <= 3'b111;
      cnt_q      <= '0;
      rep_q      <= 1'b0;
      hour_q     <= 5'd0;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_lvl;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      upd_q      <= upd_d;
    end
  end

  assign hour     = hour_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign set_mode = state_q;
  assign upd      = upd_q;

endmodule
